// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/data memory-port arbiter: FSM states, owner ids, counter widths.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // Sized for the widest legal RD_LAT (4) and STARVE_MAX (15).
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: data wins unless IF has lost STARVE_MAX contested rounds in a row.
// Zero latency; it only ranks requests, and both requesters keep req high until granted.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                if_req,
    input  logic                d_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                grant_valid,
    output owner_e              owner
);

    logic if_forced;

    always_comb begin
        grant_valid = if_req | d_req;
        if_forced   = if_req && (starve_cnt == STARVE_W'(STARVE_MAX));
        owner       = OWN_IF;
        if (d_req && !if_forced) begin
            owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF and data paths, one transaction in flight: gnt in cycle 1 after the
// sampling edge, rvalid in cycle RD_LAT+2 (reads) or 2 (writes); requesters hold req until gnt.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_e          state_q,    state_d;
    owner_e              owner_q,    owner_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic                we_q,       we_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [STARVE_W-1:0] starve_q,   starve_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q,  d_rdata_d;

    logic   pick_vld;
    owner_e pick_owner;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .starve_cnt  (starve_q),
        .grant_valid (pick_vld),
        .owner       (pick_owner)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        unique case (state_q)
            ARB_IDLE, ARB_RESP: begin
                // Starvation only accrues while IF is actually waiting behind a data win.
                if (pick_vld && (pick_owner == OWN_D) && if_req) begin
                    starve_d = (starve_q == STARVE_W'(STARVE_MAX)) ? starve_q
                                                                    : starve_q + STARVE_W'(1);
                end else begin
                    starve_d = '0;
                end
                if (pick_vld) begin
                    state_d = ARB_ISSUE;
                    owner_d = pick_owner;
                    if (pick_owner == OWN_D) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        we_d    = d_we;
                    end else begin
                        addr_d  = if_addr;
                        wdata_d = '0;
                        we_d    = 1'b0;
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                if (we_q) begin
                    state_d = ARB_RESP;
                end else begin
                    state_d = ARB_WAIT;
                    cnt_d   = CNT_W'(RD_LAT);
                end
            end
            ARB_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ARB_RESP;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Strobes decode straight from state so reset kills them without waiting for an edge.
    assign mem_en    = (state_q == ARB_ISSUE);
    assign mem_we    = (state_q == ARB_ISSUE) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_gnt    = (state_q == ARB_ISSUE) && (owner_q == OWN_IF);
    assign d_gnt     = (state_q == ARB_ISSUE) && (owner_q == OWN_D);
    assign if_rvalid = (state_q == ARB_RESP)  && (owner_q == OWN_IF);
    assign d_rvalid  = (state_q == ARB_RESP)  && (owner_q == OWN_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus queues hand-computed memory/gnt/rvalid events, a negedge monitor pops and compares.
module tb_mem_port_arbiter;

    localparam logic [2:0] K_MEM  = 3'd0;
    localparam logic [2:0] K_IGNT = 3'd1;
    localparam logic [2:0] K_DGNT = 3'd2;
    localparam logic [2:0] K_IRV  = 3'd3;
    localparam logic [2:0] K_DRV  = 3'd4;

    typedef struct packed {
        logic [2:0]  kind;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        l1_if_req, l1_if_gnt, l1_if_rvalid;
    logic [31:0] l1_if_addr, l1_if_rdata;
    logic        l1_d_gnt, l1_d_rvalid;
    logic [31:0] l1_d_rdata;
    logic        l1_mem_en, l1_mem_we, l1_busy;
    logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2), .STARVE_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .if_req(l1_if_req), .if_addr(l1_if_addr), .if_gnt(l1_if_gnt), .if_rvalid(l1_if_rvalid),
        .if_rdata(l1_if_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_gnt(l1_d_gnt), .d_rvalid(l1_d_rvalid), .d_rdata(l1_d_rdata),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_rdata(l1_mem_rdata), .busy(l1_busy)
    );

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Memory model: read data is driven only in the exact cycle RD_LAT after mem_en, zero otherwise.
    logic [31:0] mem [logic [31:0]];
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [31:0] rd0 = 32'h0, rd1 = 32'h0;

    function automatic logic [31:0] lookup(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
    end
    always @(posedge clk) begin
        v0  <= mem_en && !mem_we;
        rd0 <= lookup(mem_addr);
        v1  <= v0;
        rd1 <= rd0;
    end
    assign mem_rdata = v1 ? rd1 : 32'h0;

    logic        l1_v = 1'b0;
    logic [31:0] l1_d = 32'h0;
    always @(posedge clk) begin
        l1_v <= l1_mem_en && !l1_mem_we;
        l1_d <= l1_mem_addr ^ 32'hA5A5_0000;
    end
    assign l1_mem_rdata = l1_v ? l1_d : 32'h0;

    int  n_checks = 0;
    int  n_fail   = 0;
    ev_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ev_t mk(input logic [2:0] k, input logic we, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] c);
        ev_t e;
        e.kind = k; e.we = we; e.addr = a; e.data = d; e.cyc = c;
        return e;
    endfunction

    task automatic push(input ev_t e);
        exp_q.push_back(e);
    endtask

    task automatic take(input ev_t a);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: unexpected kind=%0d addr=%h data=%h at cycle %0d", a.kind, a.addr, a.data, a.cyc);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL event: got kind=%0d we=%0d addr=%h data=%h cyc=%0d expected kind=%0d we=%0d addr=%h data=%h cyc=%0d",
                         a.kind, a.we, a.addr, a.data, a.cyc, e.kind, e.we, e.addr, e.data, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mem_en)    take(mk(K_MEM, mem_we, mem_addr, mem_we ? mem_wdata : 32'h0, cyc));
        if (if_gnt)    take(mk(K_IGNT, 1'b0, 32'h0, 32'h0, cyc));
        if (d_gnt)     take(mk(K_DGNT, 1'b0, 32'h0, 32'h0, cyc));
        if (if_rvalid) take(mk(K_IRV, 1'b0, 32'h0, if_rdata, cyc));
        if (d_rvalid)  take(mk(K_DRV, 1'b0, 32'h0, d_rdata, cyc));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t0;
        int dg, ig;
        reset_n = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        l1_if_req = 1'b0; l1_if_addr = 32'h0;
        mem[32'h100] = 32'hDEAD_BEEF;
        mem[32'h104] = 32'hCAFE_F00D;
        mem[32'h108] = 32'h0BAD_F00D;
        repeat (3) @(negedge clk);

        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset mem_en", {31'b0, mem_en}, 32'd0);
        check("reset mem_we", {31'b0, mem_we}, 32'd0);
        check("reset gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
        check("reset rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset if_rdata", if_rdata, 32'h0);
        check("reset d_rdata", d_rdata, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // IF read
        t0 = cyc;
        push(mk(K_MEM, 1'b0, 32'h100, 32'h0, t0 + 1));
        push(mk(K_IGNT, 1'b0, 32'h0, 32'h0, t0 + 1));
        push(mk(K_IRV, 1'b0, 32'h0, 32'hDEAD_BEEF, t0 + 4));
        if_req = 1'b1; if_addr = 32'h100;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("if read busy", {31'b0, busy}, (k <= 4) ? 32'd1 : 32'd0);
            if (if_gnt) if_req = 1'b0;
        end
        if_req = 1'b0;
        check("if_rdata hold", if_rdata, 32'hDEAD_BEEF);

        // Data write
        t0 = cyc;
        push(mk(K_MEM, 1'b1, 32'h2000, 32'h1234_5678, t0 + 1));
        push(mk(K_DGNT, 1'b0, 32'h0, 32'h0, t0 + 1));
        push(mk(K_DRV, 1'b0, 32'h0, 32'h0, t0 + 2));
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h1234_5678;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("write busy", {31'b0, busy}, (k <= 2) ? 32'd1 : 32'd0);
            if (d_gnt) d_req = 1'b0;
        end
        d_req = 1'b0; d_we = 1'b0;
        check("write stored", lookup(32'h2000), 32'h1234_5678);
        check("write d_rdata unchanged", d_rdata, 32'h0);

        // Contention: D read first, IF directly after D's RESP
        t0 = cyc;
        push(mk(K_MEM, 1'b0, 32'h2000, 32'h0, t0 + 1));
        push(mk(K_DGNT, 1'b0, 32'h0, 32'h0, t0 + 1));
        push(mk(K_DRV, 1'b0, 32'h0, 32'h1234_5678, t0 + 4));
        push(mk(K_MEM, 1'b0, 32'h104, 32'h0, t0 + 5));
        push(mk(K_IGNT, 1'b0, 32'h0, 32'h0, t0 + 5));
        push(mk(K_IRV, 1'b0, 32'h0, 32'hCAFE_F00D, t0 + 8));
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_addr = 32'h2000;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (if_gnt) if_req = 1'b0;
            if (d_gnt) d_req = 1'b0;
        end
        if_req = 1'b0; d_req = 1'b0;
        check("contention idle", {31'b0, busy}, 32'd0);

        // Starvation guard: 4 data wins, IF forced, next contested round back to D
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            push(mk(K_MEM, 1'b0, 32'h2000, 32'h0, t0 + 1 + 4 * i));
            push(mk(K_DGNT, 1'b0, 32'h0, 32'h0, t0 + 1 + 4 * i));
            push(mk(K_DRV, 1'b0, 32'h0, 32'h1234_5678, t0 + 4 + 4 * i));
        end
        push(mk(K_MEM, 1'b0, 32'h108, 32'h0, t0 + 17));
        push(mk(K_IGNT, 1'b0, 32'h0, 32'h0, t0 + 17));
        push(mk(K_IRV, 1'b0, 32'h0, 32'h0BAD_F00D, t0 + 20));
        push(mk(K_MEM, 1'b0, 32'h2000, 32'h0, t0 + 21));
        push(mk(K_DGNT, 1'b0, 32'h0, 32'h0, t0 + 21));
        push(mk(K_DRV, 1'b0, 32'h0, 32'h1234_5678, t0 + 24));
        push(mk(K_MEM, 1'b0, 32'h108, 32'h0, t0 + 25));
        push(mk(K_IGNT, 1'b0, 32'h0, 32'h0, t0 + 25));
        push(mk(K_IRV, 1'b0, 32'h0, 32'h0BAD_F00D, t0 + 28));
        if_req = 1'b1; if_addr = 32'h108;
        d_req = 1'b1; d_addr = 32'h2000;
        dg = 0; ig = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (d_gnt) begin
                dg++;
                if (dg == 5) d_req = 1'b0;
            end
            if (if_gnt) begin
                ig++;
                if (ig == 2) if_req = 1'b0;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        check("starve d_gnt count", dg, 32'd5);
        check("starve if_gnt count", ig, 32'd2);

        // Reset during the second WAIT cycle
        t0 = cyc;
        push(mk(K_MEM, 1'b0, 32'h100, 32'h0, t0 + 1));
        push(mk(K_IGNT, 1'b0, 32'h0, 32'h0, t0 + 1));
        if_req = 1'b1; if_addr = 32'h100;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (if_gnt) if_req = 1'b0;
        end
        if_req = 1'b0;
        check("pre-reset busy", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async reset busy", {31'b0, busy}, 32'd0);
        check("async reset mem_en", {31'b0, mem_en}, 32'd0);
        check("async reset gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
        check("async reset rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
        check("async reset if_rdata", if_rdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        t0 = cyc;
        push(mk(K_MEM, 1'b0, 32'h104, 32'h0, t0 + 1));
        push(mk(K_IGNT, 1'b0, 32'h0, 32'h0, t0 + 1));
        push(mk(K_IRV, 1'b0, 32'h0, 32'hCAFE_F00D, t0 + 4));
        if_req = 1'b1; if_addr = 32'h104;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (if_gnt) if_req = 1'b0;
        end
        if_req = 1'b0;

        // RD_LAT=1 instance: data captured from cycle 2, rvalid in cycle 3
        l1_if_req = 1'b1; l1_if_addr = 32'h40;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("lat1 mem_en", {31'b0, l1_mem_en}, (k == 1) ? 32'd1 : 32'd0);
            check("lat1 if_gnt", {31'b0, l1_if_gnt}, (k == 1) ? 32'd1 : 32'd0);
            check("lat1 if_rvalid", {31'b0, l1_if_rvalid}, (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) check("lat1 if_rdata", l1_if_rdata, 32'hA5A5_0040);
            if (l1_if_gnt) l1_if_req = 1'b0;
        end
        l1_if_req = 1'b0;

        repeat (3) @(negedge clk);
        check("leftover expected events", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
